// File: rtl/seq16_fetch_ctrl.sv
// seq16_fetch_ctrl: serial 4-word instruction fetch, exec strobe, halt/timeout; SEQ16_RETIRE_CNT_EN adds retire_cnt
module seq16_fetch_ctrl #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [15:0] HALT_OPCODE = 16'hFFFF,
  parameter int unsigned MAX_WAIT    = 0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [15:0] instr,
  output logic [15:0] arg1,
  output logic [15:0] arg2,
  output logic [15:0] dest,
  output logic        exec_en,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic [15:0] pc,
`ifdef SEQ16_RETIRE_CNT_EN
  output logic [31:0] retire_cnt,
`endif
  output logic        halted,
  output logic        fault
);
  typedef enum logic [2:0] {IDLE, F0, F1, F2, F3, EXEC, HALT, FAULT} state_t;
  state_t state;
  logic [31:0] wait_cnt;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      mem_addr <= RESET_PC;
      mem_req <= 1'b0;
      instr <= '0;
      arg1 <= '0;
      arg2 <= '0;
      dest <= '0;
      exec_en <= 1'b0;
      halted <= 1'b0;
      fault <= 1'b0;
      wait_cnt <= '0;
`ifdef SEQ16_RETIRE_CNT_EN
      retire_cnt <= '0;
`endif
    end else begin
      exec_en <= 1'b0;
      case (state)
        IDLE: begin
          state <= F0;
          mem_req <= 1'b1;
          mem_addr <= pc;
        end
        F0, F1, F2, F3: begin
          if (mem_ack) begin
            wait_cnt <= '0;
            mem_addr <= mem_addr + 16'd1;
            if (state == F0) instr <= mem_rdata;
            if (state == F1) arg1 <= mem_rdata;
            if (state == F2) arg2 <= mem_rdata;
            if (state == F3) dest <= mem_rdata;
            if (state == F0 && mem_rdata == HALT_OPCODE) begin
              state <= HALT;
              mem_req <= 1'b0;
              halted <= 1'b1;
            end else if (state == F3) begin
              state <= EXEC;
              mem_req <= 1'b0;
              exec_en <= 1'b1;
            end else begin
              state <= state == F0 ? F1 : state == F1 ? F2 : F3;
            end
          end else if (MAX_WAIT != 0 && wait_cnt == MAX_WAIT - 1) begin
            state <= FAULT;
            mem_req <= 1'b0;
            fault <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        EXEC: begin
          pc <= branch_taken ? branch_target : pc + 16'd4;
          mem_addr <= branch_taken ? branch_target : pc + 16'd4;
          mem_req <= 1'b1;
          state <= F0;
`ifdef SEQ16_RETIRE_CNT_EN
          retire_cnt <= retire_cnt + 32'd1;
`endif
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/seq16_fetch_ctrl.md
# seq16_fetch_ctrl

Multi-cycle instruction sequencer for the 16-bit core: fetches each 4-word instruction (opcode, arg1, arg2, dest) serially over a single-ported 16-bit memory handshake, latches the words for the decoders/ALU/COND, issues a one-cycle execute strobe, then advances the PC by 4 or loads the branch target. It replaces the free-running 4-wide program port with a sequenced fetch so program memory can share one narrow port, and it owns halt and fetch-timeout detection.

## Interface

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset
- HALT_OPCODE, 16'hFFFF, opcode word that stops the sequencer
- MAX_WAIT, 0, max cycles a fetch waits for mem_ack before fault; 0 disables the timeout

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- mem_req  out  1  fetch request, registered
- mem_addr  out  16  fetch word address, registered, stable while mem_req=1
- mem_ack  in  1  memory accepts and returns data this cycle
- mem_rdata  in  16  fetch data, valid when mem_req&mem_ack
- instr  out  16  latched opcode word
- arg1  out  16  latched word pc+1
- arg2  out  16  latched word pc+2
- dest  out  16  latched word pc+3
- exec_en  out  1  one-cycle execute strobe to ALU/COND/decoders
- branch_taken  in  1  COND result, sampled in EXEC
- branch_target  in  16  jump target, sampled in EXEC
- pc  out  16  address of current instruction
- halted  out  1  sticky halt flag
- fault  out  1  sticky fetch-timeout flag

## Operation

- States: IDLE, F0, F1, F2, F3, EXEC, HALT, FAULT.
- IDLE: entered on reset; next edge -> F0 with mem_req=1, mem_addr=pc.
- Fk (k=0..3): mem_req=1, mem_addr=pc+k (mod 2^16). On edge with mem_ack=1: capture mem_rdata into instr/arg1/arg2/dest respectively, advance to F(k+1) (F3 -> EXEC), mem_addr updates to next word. mem_ack=0: hold state, address, data.
- F0 capture with mem_rdata==HALT_OPCODE: instr<=HALT_OPCODE, -> HALT; arg1/arg2/dest not fetched, keep old values.
- EXEC: mem_req=0, exec_en=1 for exactly this cycle. On edge: pc<=branch_taken ? branch_target : pc+4 (mod 2^16), -> F0.
- HALT: halted=1, mem_req=0, exec_en=0; left only by reset.
- FAULT: wait counter counts consecutive Fk cycles with mem_ack=0, reset on each ack; reaching MAX_WAIT (MAX_WAIT!=0) -> FAULT, fault=1, mem_req=0; left only by reset.
- branch_target used unaligned, as-is. pc+k and pc+4 wrap silently (pc=16'hFFFE fetches FFFE, FFFF, 0000, 0001).
- branch_taken/branch_target ignored outside EXEC.

## Timing

- Reset (rst=0 at edge): state IDLE, pc=RESET_PC, mem_addr=RESET_PC, mem_req=0, instr/arg1/arg2/dest=0, exec_en=0, halted=0, fault=0, wait counter=0. Reset mid-fetch or mid-EXEC abandons the instruction; mem_req low the cycle after the reset edge.
- All outputs registered; no combinational input-to-output path.
- Zero-wait memory (mem_ack=1 whenever requested): first exec_en pulse 5 cycles after IDLE exit edge; steady state one instruction per 5 cycles (4 fetch + 1 EXEC).
- Each wait cycle on any Fk adds one cycle.
- mem_addr changes only on an accepting edge or on EXEC->F0; never while mem_req=1 and mem_ack=0.
- halted asserts the cycle after the F0 capture of HALT_OPCODE; no exec_en is issued for it.
- Timeout: fault asserts the cycle after the MAX_WAIT-th consecutive non-ack cycle in one Fk.

## Configuration

- SEQ16_RETIRE_CNT_EN defined: adds output retire_cnt (32 bits, reset 0), incremented on every EXEC cycle, wrapping at 2^32, frozen in HALT/FAULT.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan

- Zero-wait memory with words 0x0010,0x0001,0x0002,0x0003 at 0..3: instr/arg1/arg2/dest=0010/0001/0002/0003 when exec_en pulses 5 cycles after IDLE exit; next fetch at address 4.
- mem_ack low 2 cycles during F2: exec_en delayed 2 cycles, mem_addr held at pc+2 throughout, captured arg2 correct.
- EXEC with branch_taken=1, branch_target=0x0123: next mem_addr=0x0123, pc=0x0123; with branch_taken=0, pc=pc+4.
- Word 0xFFFF at pc=8: halted=1 next cycle, mem_req=0, no exec_en, no fetch of 9..11; stays halted until rst=0.
- MAX_WAIT=3, mem_ack held 0 in F1: fault=1 after 3 wait cycles, mem_req=0; rst=0 clears fault, pc=RESET_PC.
- pc=0xFFFE, no branch: fetch addresses FFFE,FFFF,0000,0001, then pc=0x0002; with SEQ16_RETIRE_CNT_EN, retire_cnt increments once per EXEC.
